// File: rtl/ram_instrucciones_loader.sv
// Instruction memory for the MIPS pipeline: byte-stream program loader (valid/ready, MSB first,
// stops on HALT or when full) plus a registered, byte-addressed fetch port with flush-to-NOP.
module ram_instrucciones_loader #(
    parameter int                   RAM_WIDTH   = 32,
    parameter int                   RAM_DEPTH   = 2048,
    parameter int                   ADDR_WIDTH  = 32,
    parameter int                   OUT_REG     = 0,
    parameter logic [5:0]           HALT_OPCODE = 6'b111111,
    parameter logic [RAM_WIDTH-1:0] NOP_WORD    = '0,
    localparam int                  COUNT_W     = $clog2(RAM_DEPTH) + 1
) (
    input  logic                  clka,
    input  logic                  reset,
    input  logic                  load_start,
    input  logic                  load_valid,
    input  logic [7:0]            load_byte,
    output logic                  load_ready,
    output logic                  load_done,
    output logic                  load_overflow,
    output logic [COUNT_W-1:0]    load_count,
    input  logic                  ena,
    input  logic                  flush,
    input  logic [ADDR_WIDTH-1:0] addra,
    output logic [RAM_WIDTH-1:0]  douta,
    output logic                  halt,
    output logic                  out_of_range,
    output logic                  busy
);

    localparam int BYTES  = RAM_WIDTH / 8;
    localparam int BYTE_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int MEM_AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

    state_t               state, state_next;
    logic [BYTE_W-1:0]    byte_cnt;
    logic [COUNT_W-1:0]   word_addr;
    logic [COUNT_W-1:0]   word_addr_inc;
    logic [RAM_WIDTH-1:0] asm_word;
    logic                 done_q, ovf_q;
    logic                 accept, wr_en, byte_last, word_is_halt, last_word;

    assign word_addr_inc = word_addr + COUNT_W'(1);
    assign byte_last     = (byte_cnt == BYTE_W'(BYTES - 1));
    assign word_is_halt  = (asm_word[RAM_WIDTH-1 -: 6] == HALT_OPCODE);
    assign last_word     = (word_addr_inc == COUNT_W'(RAM_DEPTH));

    // load_start wins in every state: it restarts at word 0 and drops any partial word.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_next = state;
        accept     = 1'b0;
        wr_en      = 1'b0;
        load_ready = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: if (load_start) state_next = LOAD;
            LOAD: begin
                load_ready = 1'b1;
                busy       = 1'b1;
                if (load_start) begin
                    state_next = LOAD;
                end else if (load_valid) begin
                    accept = 1'b1;
                    if (byte_last) state_next = WRITE;
                end
            end
            WRITE: begin
                busy = 1'b1;
                if (load_start) begin
                    state_next = LOAD;
                end else begin
                    wr_en      = 1'b1;
                    state_next = (word_is_halt || last_word) ? DONE : LOAD;
                end
            end
            DONE:    if (load_start) state_next = LOAD;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clka) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!reset) begin
            state     <= IDLE;
            byte_cnt  <= '0;
            word_addr <= '0;
            asm_word  <= '0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state <= state_next;
            if (load_start) begin
                byte_cnt  <= '0;
                word_addr <= '0;
                done_q    <= 1'b0;
                ovf_q     <= 1'b0;
            end else begin
                if (accept) begin
                    asm_word <= RAM_WIDTH'({asm_word, load_byte});
                    byte_cnt <= byte_last ? '0 : byte_cnt + BYTE_W'(1);
                end
                if (wr_en) begin
                    word_addr <= word_addr_inc;
                    if (word_is_halt)   done_q <= 1'b1;
                    else if (last_word) ovf_q  <= 1'b1;
                end
            end
        end
    end

    assign load_count    = word_addr;
    assign load_done     = done_q;
    assign load_overflow = ovf_q;

    logic [RAM_WIDTH-1:0]  mem [RAM_DEPTH];
    logic [RAM_WIDTH-1:0]  rd_q;
    logic [ADDR_WIDTH-1:0] fetch_idx;
    logic                  in_range;

    assign fetch_idx = addra >> 2;
    assign in_range  = (fetch_idx < ADDR_WIDTH'(RAM_DEPTH));

    // NOTE: the array and its read register carry no reset so the tools can map them to block RAM;
    // the program survives a reset. Reading here sees the pre-write word (read-first).
    always_ff @(posedge clka) begin
        if (wr_en) mem[word_addr[MEM_AW-1:0]] <= asm_word;
        if (ena)   rd_q <= mem[fetch_idx[MEM_AW-1:0]];
    end

    // Source select is registered alongside the read; flush > busy > out-of-range > RAM.
    logic use_ram_q, oor_q;
    always_ff @(posedge clka) begin
        if (!reset) begin
            use_ram_q <= 1'b0;
            oor_q     <= 1'b0;
        end else if (ena) begin
            use_ram_q <= !(flush || busy) && in_range;
            oor_q     <= !(flush || busy) && !in_range;
        end
    end

    logic [RAM_WIDTH-1:0] s1_word;
    logic                 s1_halt;
    assign s1_word = use_ram_q ? rd_q : NOP_WORD;
    assign s1_halt = use_ram_q && (rd_q[RAM_WIDTH-1 -: 6] == HALT_OPCODE);

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [RAM_WIDTH-1:0] s2_word;
            logic                 s2_halt, s2_oor;
            always_ff @(posedge clka) begin
                if (!reset) begin
                    s2_word <= NOP_WORD;
                    s2_halt <= 1'b0;
                    s2_oor  <= 1'b0;
                end else if (ena) begin
                    s2_word <= s1_word;
                    s2_halt <= s1_halt;
                    s2_oor  <= oor_q;
                end
            end
            assign douta        = s2_word;
            assign halt         = s2_halt;
            assign out_of_range = s2_oor;
        end else begin : g_no_out_reg
            assign douta        = s1_word;
            assign halt         = s1_halt;
            assign out_of_range = oor_q;
        end
    endgenerate

endmodule

// File: tb/tb_ram_instrucciones_loader.sv
// Directed bench: a default instance (2048 words, 1-cycle fetch) and a 4-word instance with OUT_REG=1.
module tb_ram_instrucciones_loader;

    logic clka = 1'b0;
    always #5 clka = ~clka;

    logic        reset, ena, flush;
    logic [31:0] addra;
    logic        load_start [2];
    logic        load_valid [2];
    logic [7:0]  load_byte  [2];
    logic        load_ready [2];
    logic        load_done  [2];
    logic        load_ovf   [2];
    logic        busy       [2];
    logic [31:0] douta_m, douta_s;
    logic        halt_m, halt_s, oor_m, oor_s;
    logic [11:0] count_m;
    logic [2:0]  count_s;

    int n_pass = 0, n_total = 0, wait_ticks = 0;

    ram_instrucciones_loader dut_main (
        .clka(clka), .reset(reset),
        .load_start(load_start[0]), .load_valid(load_valid[0]), .load_byte(load_byte[0]),
        .load_ready(load_ready[0]), .load_done(load_done[0]), .load_overflow(load_ovf[0]),
        .load_count(count_m), .ena(ena), .flush(flush), .addra(addra),
        .douta(douta_m), .halt(halt_m), .out_of_range(oor_m), .busy(busy[0])
    );

    ram_instrucciones_loader #(.RAM_DEPTH(4), .OUT_REG(1)) dut_small (
        .clka(clka), .reset(reset),
        .load_start(load_start[1]), .load_valid(load_valid[1]), .load_byte(load_byte[1]),
        .load_ready(load_ready[1]), .load_done(load_done[1]), .load_overflow(load_ovf[1]),
        .load_count(count_s), .ena(ena), .flush(flush), .addra(addra),
        .douta(douta_s), .halt(halt_s), .out_of_range(oor_s), .busy(busy[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clka);
        #1;
    endtask

    task automatic send_byte(input int u, input logic [7:0] b);
        int n = 0;
        load_valid[u] = 1'b1;
        load_byte[u]  = b;
        while (!load_ready[u] && n < 20) begin
            tick();
            n++;
            wait_ticks++;
        end
        if (n >= 20) check("ready_timeout", 32'(load_ready[u]), 32'd1);
        tick();
        load_valid[u] = 1'b0;
    endtask

    task automatic load_seq(input int u, input logic [127:0] data, input int n);
        for (int i = 0; i < n; i++) send_byte(u, data[8*(n-1-i) +: 8]);
    endtask

    task automatic pulse_start(input int u);
        load_start[u] = 1'b1;
        tick();
        load_start[u] = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] a);
        addra = a;
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; ena = 1'b0; flush = 1'b0; addra = '0;
        for (int u = 0; u < 2; u++) begin
            load_start[u] = 1'b0; load_valid[u] = 1'b0; load_byte[u] = '0;
        end
        tick(); tick();
        check("rst_douta",      douta_m,               32'h0);
        check("rst_halt",       32'(halt_m),           32'd0);
        check("rst_load_ready", 32'(load_ready[0]),    32'd0);
        check("rst_busy",       32'(busy[0]),          32'd0);
        check("rst_count",      32'(count_m),          32'd0);
        check("rst_done",       32'(load_done[0]),     32'd0);
        reset = 1'b1;

        // Basic load: two words, second one is HALT.
        pulse_start(0);
        check("s2_busy", 32'(busy[0]), 32'd1);
        wait_ticks = 0;
        load_seq(0, 128'h20080005_FC000000, 8);
        check("s2_ready_in_write", 32'(load_ready[0]), 32'd0);
        tick();
        check("s2_done",      32'(load_done[0]), 32'd1);
        check("s2_overflow",  32'(load_ovf[0]),  32'd0);
        check("s2_count",     32'(count_m),      32'd2);
        check("s2_busy_idle", 32'(busy[0]),      32'd0);
        check("s2_ready_gap", 32'(wait_ticks),   32'd1);
        ena = 1'b1;
        fetch(32'd0);
        check("s2_word0",      douta_m,       32'h20080005);
        check("s2_word0_halt", 32'(halt_m),   32'd0);
        fetch(32'd4);
        check("s2_word1",      douta_m,       32'hFC000000);
        check("s2_word1_halt", 32'(halt_m),   32'd1);

        // Reload with a 3-cycle gap in load_valid mid-word.
        pulse_start(0);
        check("s3_done_cleared", 32'(load_done[0]), 32'd0);
        wait_ticks = 0;
        load_seq(0, 128'h2008, 2);
        check("s3_nop_while_busy", douta_m, 32'h0);
        tick(); tick(); tick();
        load_seq(0, 128'h0005_FC000000, 6);
        tick();
        check("s3_done",      32'(load_done[0]), 32'd1);
        check("s3_count",     32'(count_m),      32'd2);
        check("s3_ready_gap", 32'(wait_ticks),   32'd1);
        fetch(32'd0);
        check("s3_word0", douta_m, 32'h20080005);
        fetch(32'd4);
        check("s3_word1", douta_m, 32'hFC000000);

        // Flush, ena hold, out-of-range, ignored low address bits.
        flush = 1'b1;
        fetch(32'd0);
        check("s5_flush_douta", douta_m,     32'h0);
        check("s5_flush_halt",  32'(halt_m), 32'd0);
        flush = 1'b0;
        fetch(32'd4);
        check("s5_refetch", douta_m, 32'hFC000000);
        ena = 1'b0;
        fetch(32'd0);
        check("s5_hold_douta", douta_m,     32'hFC000000);
        check("s5_hold_halt",  32'(halt_m), 32'd1);
        ena = 1'b1;
        fetch(32'd8192);
        check("s5_oor_douta", douta_m,     32'h0);
        check("s5_oor_flag",  32'(oor_m),  32'd1);
        check("s5_oor_halt",  32'(halt_m), 32'd0);
        fetch(32'd3);
        check("s5_unaligned", douta_m,    32'h20080005);
        check("s5_oor_clear", 32'(oor_m), 32'd0);

        // Reset in the middle of a load (after 5 bytes).
        pulse_start(0);
        load_seq(0, 128'h11223344_AA, 5);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("s6_busy",   32'(busy[0]),       32'd0);
        check("s6_ready",  32'(load_ready[0]), 32'd0);
        check("s6_count",  32'(count_m),       32'd0);
        check("s6_douta",  douta_m,            32'h0);
        fetch(32'd0);
        check("s6_word0_kept", douta_m, 32'h11223344);
        fetch(32'd4);
        check("s6_word1_kept", douta_m,     32'hFC000000);
        check("s6_word1_halt", 32'(halt_m), 32'd1);

        // Restart while in LOAD discards the partial word.
        pulse_start(0);
        load_seq(0, 128'h9999, 2);
        pulse_start(0);
        load_seq(0, 128'h24000007_FC000001, 8);
        tick();
        check("rs_done",  32'(load_done[0]), 32'd1);
        check("rs_count", 32'(count_m),      32'd2);
        fetch(32'd0);
        check("rs_word0", douta_m, 32'h24000007);
        fetch(32'd4);
        check("rs_word1", douta_m,     32'hFC000001);
        check("rs_halt",  32'(halt_m), 32'd1);

        // Small instance: fill without HALT, then 2-cycle fetch latency.
        pulse_start(1);
        load_seq(1, 128'h00010203_04050607_08090A0B_0C0D0E0F, 16);
        tick();
        check("s4_overflow", 32'(load_ovf[1]),  32'd1);
        check("s4_done",     32'(load_done[1]), 32'd0);
        check("s4_count",    32'(count_s),      32'd4);
        check("s4_busy",     32'(busy[1]),      32'd0);
        addra = 32'd4;
        tick(); tick();
        check("s4_word1", douta_s, 32'h04050607);
        addra = 32'd8;
        tick();
        check("s4_latency_hold", douta_s, 32'h04050607);
        tick();
        check("s4_word2", douta_s, 32'h08090A0B);
        addra = 32'd16;
        tick(); tick();
        check("s4_oor_flag",  32'(oor_s), 32'd1);
        check("s4_oor_douta", douta_s,    32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
